// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads through a
// prefetch output register. Leave it undefined for standard reads with
// one cycle of latency.
module fifo_sync #(
    parameter int WIDTH         = 36,
    parameter int DEPTH         = 512,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         DI,
    input  logic                     WREN,
    output logic                     FULL,
    output logic                     AFULL,
    output logic [WIDTH-1:0]         DO,
    input  logic                     RDEN,
    output logic                     EMPTY,
    output logic                     AEMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     WRERR,
    output logic                     RDERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             empty_q, empty_d;
    logic             aempty_q, aempty_d;
    logic             wrerr_q, wrerr_d;
    logic             rderr_q, rderr_d;

    logic             wr_acc;   // write accepted this edge
    logic             rd_acc;   // word leaves the FIFO this edge
    logic             pop_mem;  // storage array head is consumed this edge

    // Requests are dropped entirely while reset is held.
    assign wr_acc = WREN && !full_q  && !RST;
    assign rd_acc = RDEN && !empty_q && !RST;

`ifdef FIFO_SYNC_FWFT_EN
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] stored;

    // Words sitting in the array, excluding the one held in the output register.
    assign stored  = count_q - CW'(out_valid_q);
    // Refill the output register whenever it is empty or being consumed.
    assign pop_mem = !RST && (stored != '0) && (!out_valid_q || rd_acc);
`else
    assign pop_mem = rd_acc;
`endif

    // Next-state computation for pointers, count, flags and output data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop_mem);
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        do_d     = pop_mem ? mem_q[rd_ptr_q] : do_q;
        full_d   = (count_d == CW'(DEPTH));
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
        wrerr_d  = wrerr_q | (WREN && full_q);
        rderr_d  = rderr_q | (RDEN && empty_q);
`ifdef FIFO_SYNC_FWFT_EN
        out_valid_d = out_valid_q;
        if (pop_mem) begin
            out_valid_d = 1'b1;
        end else if (rd_acc) begin
            out_valid_d = 1'b0;
        end
        empty_d = !out_valid_d;
`else
        empty_d = (count_d == '0);
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            do_q     <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            do_q     <= do_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            wrerr_q  <= wrerr_d;
            rderr_q  <= rderr_d;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Output-register valid bit for the prefetch stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end
`endif

    // Storage array write port.
    always_ff @(posedge CLK) begin
        // NOTE: the array is not reset; resetting the pointers makes old contents unreachable.
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= DI;
        end
    end

    assign FULL   = full_q;
    assign AFULL  = afull_q;
    assign EMPTY  = empty_q;
    assign AEMPTY = aempty_q;
    assign COUNT  = count_q;
    assign DO     = do_q;
    assign WRERR  = wrerr_q;
    assign RDERR  = rderr_q;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed self-checking bench for fifo_sync
// (WIDTH=36, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4).
module tb_fifo_sync;

    localparam int WIDTH = 36;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] di;
    logic             wren;
    logic             rden;
    logic             full;
    logic             afull;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             aempty;
    logic [4:0]       count;
    logic             wrerr;
    logic             rderr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_w;

    always #5 clk = ~clk;

    fifo_sync #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (12),
        .AEMPTY_THRESH(4)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .DI    (di),
        .WREN  (wren),
        .FULL  (full),
        .AFULL (afull),
        .DO    (dout),
        .RDEN  (rden),
        .EMPTY (empty),
        .AEMPTY(aempty),
        .COUNT (count),
        .WRERR (wrerr),
        .RDERR (rderr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        wren = 1'b0;
        rden = 1'b0;
        di   = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_count",  64'(count),  64'd0);
        check("rst_empty",  64'(empty),  64'd1);
        check("rst_aempty", 64'(aempty), 64'd1);
        check("rst_full",   64'(full),   64'd0);
        check("rst_afull",  64'(afull),  64'd0);
        check("rst_do",     64'(dout),   64'd0);
        check("rst_wrerr",  64'(wrerr),  64'd0);
        check("rst_rderr",  64'(rderr),  64'd0);

        // Fill with 0..15.
        for (int i = 0; i < 16; i++) begin
            di   = WIDTH'(i);
            wren = 1'b1;
            step();
            check("fill_count",  64'(count),  64'(i + 1));
            check("fill_afull",  64'(afull),  64'((i + 1) >= 12));
            check("fill_full",   64'(full),   64'((i + 1) == 16));
            check("fill_aempty", 64'(aempty), 64'((i + 1) <= 4));
        end

        // 17th write is dropped.
        di = WIDTH'('h99);
        step();
        wren = 1'b0;
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_wrerr", 64'(wrerr), 64'd1);
        check("ovf_full",  64'(full),  64'd1);

        // Drain with RDEN held.
        rden = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef FIFO_SYNC_FWFT_EN
            exp_w = (i < 15) ? WIDTH'(i + 1) : WIDTH'(15);
`else
            exp_w = WIDTH'(i);
`endif
            check("drain_do",    64'(dout),  64'(exp_w));
            check("drain_count", 64'(count), 64'(15 - i));
            check("drain_empty", 64'(empty), 64'(i == 15));
        end

        // One read too many.
        step();
        rden = 1'b0;
        check("unf_rderr", 64'(rderr), 64'd1);
        check("unf_do",    64'(dout),  64'd15);
        check("unf_count", 64'(count), 64'd0);

        // Preload 8 words, then stream read+write for 100 cycles.
        wren = 1'b1;
        for (int k = 0; k < 8; k++) begin
            di = WIDTH'(100 + k);
            q.push_back(di);
            step();
        end
        check("pre_count", 64'(count), 64'd8);
        rden = 1'b1;
        for (int k = 0; k < 100; k++) begin
            di = WIDTH'(200 + k);
            step();
`ifdef FIFO_SYNC_FWFT_EN
            void'(q.pop_front());
            q.push_back(di);
            exp_w = q[0];
`else
            exp_w = q.pop_front();
            q.push_back(di);
`endif
            check("stream_do",    64'(dout),  64'(exp_w));
            check("stream_count", 64'(count), 64'd8);
        end
        rden = 1'b0;
        check("sticky_wrerr", 64'(wrerr), 64'd1);
        check("sticky_rderr", 64'(rderr), 64'd1);

        // Two more writes bring COUNT to 10.
        di = WIDTH'('h300);
        step();
        di = WIDTH'('h301);
        step();
        wren = 1'b0;
        check("pre_rst_count", 64'(count), 64'd10);

        // Reset mid-operation with a write pending.
        rst  = 1'b1;
        wren = 1'b1;
        di   = WIDTH'('h77);
        step();
        rst  = 1'b0;
        wren = 1'b0;
        check("mrst_count",  64'(count),  64'd0);
        check("mrst_empty",  64'(empty),  64'd1);
        check("mrst_wrerr",  64'(wrerr),  64'd0);
        check("mrst_rderr",  64'(rderr),  64'd0);
        check("mrst_do",     64'(dout),   64'd0);
        check("mrst_full",   64'(full),   64'd0);
        check("mrst_afull",  64'(afull),  64'd0);
        check("mrst_aempty", 64'(aempty), 64'd1);
        step();
        check("mrst_nostore_count", 64'(count), 64'd0);
        check("mrst_nostore_empty", 64'(empty), 64'd1);

        // Simultaneous write and read on an empty FIFO.
        di   = WIDTH'('h5A);
        wren = 1'b1;
        rden = 1'b1;
        step();
        wren = 1'b0;
        rden = 1'b0;
        check("wr_rd_empty_count", 64'(count), 64'd1);
        check("wr_rd_empty_rderr", 64'(rderr), 64'd1);
        check("wr_rd_empty_wrerr", 64'(wrerr), 64'd0);
        step();
        check("wr_rd_idle_empty", 64'(empty), 64'd0);
        check("wr_rd_idle_count", 64'(count), 64'd1);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("wr_rd_read_do",    64'(dout),  64'h5A);
        check("wr_rd_read_count", 64'(count), 64'd0);
        check("wr_rd_read_empty", 64'(empty), 64'd1);

        // Single word into an empty FIFO: fall-through latency.
        di   = WIDTH'('hA5);
        wren = 1'b1;
        step();
        wren = 1'b0;
`ifdef FIFO_SYNC_FWFT_EN
        check("a5_e_empty", 64'(empty), 64'd1);
        check("a5_e_count", 64'(count), 64'd1);
        step();
        check("a5_e1_empty", 64'(empty), 64'd0);
        check("a5_e1_do",    64'(dout),  64'hA5);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("a5_rd_empty", 64'(empty), 64'd1);
        check("a5_rd_count", 64'(count), 64'd0);
`else
        check("a5_e_empty", 64'(empty), 64'd0);
        check("a5_e_count", 64'(count), 64'd1);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("a5_rd_do",    64'(dout),  64'hA5);
        check("a5_rd_empty", 64'(empty), 64'd1);
        check("a5_rd_count", 64'(count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised single-clock FIFO for buffering data words between pipeline stages in one clock domain. It replaces the fixed 36-bit, primitive-bound output FIFO and is generic in width and depth. It adds programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through or standard read mode.

## Interface
Parameters:
- WIDTH, 36: data word width in bits (≥1).
- DEPTH, 512: capacity in words; power of two, ≥4.
- AFULL_THRESH, DEPTH-4: AFULL asserts when COUNT ≥ this value; range 1..DEPTH.
- AEMPTY_THRESH, 4: AEMPTY asserts when COUNT ≤ this value; range 0..DEPTH-1.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- DI  in  WIDTH  write data.
- WREN  in  1  write request.
- FULL  out  1  COUNT == DEPTH.
- AFULL  out  1  COUNT ≥ AFULL_THRESH.
- DO  out  WIDTH  read data.
- RDEN  in  1  read request (pop).
- EMPTY  out  1  no word available to read.
- AEMPTY  out  1  COUNT ≤ AEMPTY_THRESH.
- COUNT  out  $clog2(DEPTH)+1  words held.
- WRERR  out  1  sticky: a write was attempted while FULL.
- RDERR  out  1  sticky: a read was attempted while EMPTY.

## Operation
- Storage is a DEPTH-entry array with read and write pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- A write is accepted on an edge when WREN=1 and FULL=0. DI is stored at the write pointer, and the write pointer increments.
- A write attempted while FULL=1 is dropped, and WRERR is set. This applies even when a read occurs in the same cycle.
- A read is accepted on an edge when RDEN=1 and EMPTY=0. A read attempted while EMPTY=1 is ignored, and RDERR is set.
- Simultaneous accepted read and write: COUNT is unchanged and both pointers advance.
- When the FIFO is empty, a simultaneous WREN and RDEN accepts only the write.
- FULL, AFULL, AEMPTY and COUNT are registered. They reflect the state after each edge with no lag.
- In FWFT mode, COUNT includes the word held in the output register.
- Capacity is DEPTH words in both modes.
- WRERR and RDERR clear only on RST.
- Reset (including mid-operation) discards all contents:
  - pointers = 0, COUNT = 0;
  - EMPTY = 1, AEMPTY = 1, FULL = 0, AFULL = 0;
  - DO = 0, WRERR = 0, RDERR = 0.
- WREN and RDEN are ignored while RST=1.

## Timing
- Standard mode:
  - EMPTY deasserts after the edge that accepts the first write.
  - A read accepted at edge E drives the head word onto DO after edge E (one-cycle read latency).
  - DO holds its value when no read is accepted.
- FWFT mode:
  - A write into an empty FIFO at edge E gives valid DO and EMPTY=0 after edge E+1 (one cycle of fall-through latency).
  - While EMPTY=0, DO always presents the head word. RDEN acknowledges it.
  - After a read at edge E, the next word is on DO after edge E, with no bubble, when storage holds ≥1 further word.
  - Otherwise EMPTY asserts after edge E, and DO holds its stale value.
- Back-to-back: one write and one read per cycle are sustained indefinitely at any occupancy 1..DEPTH-1.
- Wrap-around: no behavioural change when pointers cross DEPTH-1 → 0.

## Configuration
- FIFO_SYNC_FWFT_EN defined: first-word-fall-through read mode as described above, with a prefetch output register.
- Undefined: standard read mode with one-cycle latency. The prefetch logic is not present.
- All flag and count rules are identical in both modes.

## Test plan
- Reset, then fill to full (WIDTH=36, DEPTH=16, writes of 0..15):
  - COUNT increments each edge;
  - AFULL rises when COUNT=12;
  - FULL=1 at COUNT=16;
  - a 17th write sets WRERR=1 and COUNT stays 16.
- Drain the full FIFO with RDEN held:
  - DO sequence is 0..15 (standard mode: one cycle after each read);
  - EMPTY=1 after the 16th read;
  - one further RDEN sets RDERR=1 and DO holds 15.
- Continuous simultaneous read/write for 100 cycles at COUNT=8, with pointers wrapping ≥5 times:
  - COUNT stays 8;
  - output order matches input order exactly.
- FWFT build, write 0xA5 into an empty FIFO at edge E:
  - EMPTY=0 and DO=0xA5 after edge E+1;
  - RDEN for one cycle returns EMPTY=1 and COUNT=0.
- Assert RST for one cycle with COUNT=10 and WREN=1:
  - afterwards COUNT=0, EMPTY=1, WRERR=0, RDERR=0, DO=0;
  - the write in the reset cycle is not stored.
- Empty FIFO with WREN=1 and RDEN=1 in the same cycle:
  - write accepted, COUNT=1;
  - RDERR=1.
